// File: rtl/uart_host_ctrl_pkg.sv
// Shared types and constants for the UART host controller: FSM state encodings,
// error-bit positions inside a stored RX entry, and default sizing.
package uart_host_ctrl_pkg;

  localparam int DEF_TX_DEPTH = 8;
  localparam int DEF_RX_DEPTH = 8;
  localparam int DEF_WAIT_MAX = 32;

  // RX FIFO entry is {frame_error, parity_error, data[7:0]}
  localparam int RX_W    = 10;
  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_WR   = 2'd1,
    T_WAIT = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_RD   = 2'd1,
    R_WAIT = 2'd2
  } rx_state_e;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_host_ctrl_if.sv
// Host-side stream ports plus the UART-facing strobe/data pins of uart_host_ctrl.
// slave = controller view, master = fabric/UART view.
interface uart_host_ctrl_if #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
);
  import uart_host_ctrl_pkg::*;

  localparam int TX_LW = lvl_w(TX_DEPTH);
  localparam int RX_LW = lvl_w(RX_DEPTH);

  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic [1:0]       rx_err;
  logic             rx_valid;
  logic             rx_ready;
  logic [TX_LW-1:0] tx_level;
  logic [RX_LW-1:0] rx_level;
  logic             timeout;
  logic             err_clr;
  logic [7:0]       par_cnt;
  logic [7:0]       frm_cnt;
  logic             u_wrn;
  logic [7:0]       u_d_in;
  logic             u_t_empty;
  logic             u_rdn;
  logic [7:0]       u_d_out;
  logic             u_r_ready;
  logic             u_parity_error;
  logic             u_frame_error;

  modport slave (
    input  tx_data, tx_valid, rx_ready, err_clr,
           u_t_empty, u_d_out, u_r_ready, u_parity_error, u_frame_error,
    output tx_ready, rx_data, rx_err, rx_valid, tx_level, rx_level,
           timeout, par_cnt, frm_cnt, u_wrn, u_d_in, u_rdn
  );

  modport master (
    output tx_data, tx_valid, rx_ready, err_clr,
           u_t_empty, u_d_out, u_r_ready, u_parity_error, u_frame_error,
    input  tx_ready, rx_data, rx_err, rx_valid, tx_level, rx_level,
           timeout, par_cnt, frm_cnt, u_wrn, u_d_in, u_rdn
  );

endinterface

// File: rtl/uart_ctrl_fifo.sv
// Register-based FIFO with separate occupancy counter; DEPTH must be a power of two
// so the pointers wrap naturally. A pop on an empty FIFO is ignored.
module uart_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk16x,
  input  logic                       clrn,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_din,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic [WIDTH-1:0]           o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_ctrl.sv
// Host-side TX/RX sequencer for full_duplex_uart, clocked by the x16 clock.
// Optional parity/frame error counters are built when UART_ERR_CNT_EN is defined.
//
// state  | meaning
// T_IDLE | wait for TX data and an empty UART transmitter; pop head into u_d_in
// T_WR   | u_wrn low for one cycle
// T_WAIT | wait for u_t_empty=0 (accepted) or WAIT_MAX cycles (timeout, byte dropped)
// R_IDLE | wait for u_r_ready with room in the RX FIFO
// R_RD   | u_rdn low for one cycle; byte and error bits pushed at its end
// R_WAIT | wait for u_r_ready=0 or WAIT_MAX cycles (timeout)
module uart_host_ctrl
  import uart_host_ctrl_pkg::*;
#(
  parameter int TX_DEPTH = DEF_TX_DEPTH,
  parameter int RX_DEPTH = DEF_RX_DEPTH,
  parameter int WAIT_MAX = DEF_WAIT_MAX
) (
  input  logic              clk16x,
  input  logic              clrn,
  uart_host_ctrl_if.slave   bus
);

  localparam int TW = $clog2(WAIT_MAX + 1);

  tx_state_e        r_tx_state;
  rx_state_e        r_rx_state;
  logic             r_wrn;
  logic             r_rdn;
  logic [7:0]       r_d_in;
  logic [TW-1:0]    r_tx_tmr;
  logic [TW-1:0]    r_rx_tmr;
  logic             r_timeout;

  logic             w_tx_full;
  logic             w_tx_empty;
  logic [7:0]       w_tx_head;
  logic             w_tx_push;
  logic             w_tx_pop;
  logic             w_tx_to;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic [RX_W-1:0]  w_rx_head;
  logic [RX_W-1:0]  w_rx_din;
  logic             w_rx_push;
  logic             w_rx_to;

  assign w_tx_push   = bus.tx_valid & ~w_tx_full;
  assign bus.tx_ready = ~w_tx_full;

  uart_ctrl_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk16x  (clk16x),
    .clrn    (clrn),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_din   (bus.tx_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_level (bus.tx_level),
    .o_head  (w_tx_head)
  );

  assign w_rx_din  = {bus.u_frame_error, bus.u_parity_error, bus.u_d_out};
  assign w_rx_push = (r_rx_state == R_RD);

  uart_ctrl_fifo #(.WIDTH(RX_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk16x  (clk16x),
    .clrn    (clrn),
    .i_push  (w_rx_push),
    .i_pop   (bus.rx_ready),
    .i_din   (w_rx_din),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_level (bus.rx_level),
    .o_head  (w_rx_head)
  );

  assign bus.rx_valid = ~w_rx_empty;
  assign bus.rx_data  = w_rx_head[7:0];
  assign bus.rx_err   = w_rx_head[RX_W-1:8];
  assign bus.u_wrn    = r_wrn;
  assign bus.u_rdn    = r_rdn;
  assign bus.u_d_in   = r_d_in;
  assign bus.timeout  = r_timeout;

  assign w_tx_pop = (r_tx_state == T_IDLE) & ~w_tx_empty & bus.u_t_empty;
  assign w_tx_to  = (r_tx_state == T_WAIT) & bus.u_t_empty & (r_tx_tmr == '0);
  assign w_rx_to  = (r_rx_state == R_WAIT) & bus.u_r_ready & (r_rx_tmr == '0);

  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      r_tx_state <= T_IDLE;
      r_wrn      <= 1'b1;
      r_d_in     <= '0;
      r_tx_tmr   <= '0;
    end else begin
      case (r_tx_state)
        T_IDLE: if (w_tx_pop) begin
          r_d_in     <= w_tx_head;
          r_wrn      <= 1'b0;
          r_tx_state <= T_WR;
        end
        T_WR: begin
          r_wrn      <= 1'b1;
          r_tx_tmr   <= TW'(WAIT_MAX - 1);
          r_tx_state <= T_WAIT;
        end
        T_WAIT: begin
          if (!bus.u_t_empty || w_tx_to) r_tx_state <= T_IDLE;
          else                           r_tx_tmr   <= r_tx_tmr - 1'b1;
        end
        default: begin
          r_wrn      <= 1'b1;
          r_tx_state <= T_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      r_rx_state <= R_IDLE;
      r_rdn      <= 1'b1;
      r_rx_tmr   <= '0;
    end else begin
      case (r_rx_state)
        R_IDLE: if (bus.u_r_ready && !w_rx_full) begin
          r_rdn      <= 1'b0;
          r_rx_state <= R_RD;
        end
        R_RD: begin
          r_rdn      <= 1'b1;
          r_rx_tmr   <= TW'(WAIT_MAX - 1);
          r_rx_state <= R_WAIT;
        end
        R_WAIT: begin
          if (!bus.u_r_ready || w_rx_to) r_rx_state <= R_IDLE;
          else                           r_rx_tmr   <= r_rx_tmr - 1'b1;
        end
        default: begin
          r_rdn      <= 1'b1;
          r_rx_state <= R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn)                  r_timeout <= 1'b0;
    else if (bus.err_clr)       r_timeout <= 1'b0;
    else if (w_tx_to | w_rx_to) r_timeout <= 1'b1;
  end

`ifdef UART_ERR_CNT_EN
  logic [7:0] r_par_cnt;
  logic [7:0] r_frm_cnt;

  // Saturating counts of error-tagged bytes entering the RX FIFO.
  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      r_par_cnt <= '0;
      r_frm_cnt <= '0;
    end else if (bus.err_clr) begin
      r_par_cnt <= '0;
      r_frm_cnt <= '0;
    end else if (w_rx_push) begin
      if (w_rx_din[8+ERR_PAR] && r_par_cnt != 8'hFF) r_par_cnt <= r_par_cnt + 1'b1;
      if (w_rx_din[8+ERR_FRM] && r_frm_cnt != 8'hFF) r_frm_cnt <= r_frm_cnt + 1'b1;
    end
  end

  assign bus.par_cnt = r_par_cnt;
  assign bus.frm_cnt = r_frm_cnt;
`else
  assign bus.par_cnt = '0;
  assign bus.frm_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Bench for uart_host_ctrl with a behavioural UART loopback model; table-driven byte
// vectors plus directed sequences for full FIFOs, strobe timeout and mid-byte reset.
module tb_uart_host_ctrl;
  import uart_host_ctrl_pkg::*;

  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam int W   = 32;
  localparam int NV  = 5;

  logic clk16x = 1'b0;
  logic clrn   = 1'b0;
  always #5 clk16x = ~clk16x;

  uart_host_ctrl_if #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) bus ();

  uart_host_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .WAIT_MAX(W)) dut (
    .clk16x (clk16x),
    .clrn   (clrn),
    .bus    (bus)
  );

  // UART model knobs: t_mode 0=model, 1=t_empty tied 1, 2=t_empty tied 0
  int   t_mode  = 0;
  logic r_tie   = 1'b0;
  logic loop_en = 1'b0;
  logic inj_par = 1'b0;
  logic inj_frm = 1'b0;

  logic [9:0] m_mem [0:31];
  logic [4:0] m_wr, m_rd;
  logic [1:0] m_gap, m_busy;
  logic [9:0] m_head;

  always @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      m_wr <= '0; m_rd <= '0; m_gap <= '0; m_busy <= '0;
    end else begin
      if (bus.u_wrn == 1'b0) begin
        m_busy <= 2'd3;
        if (loop_en) begin
          m_mem[m_wr] <= {inj_frm, inj_par, bus.u_d_in};
          m_wr <= m_wr + 5'd1;
        end
      end else if (m_busy != 2'd0) m_busy <= m_busy - 2'd1;
      if (bus.u_rdn == 1'b0) begin
        if (m_wr != m_rd) m_rd <= m_rd + 5'd1;
        m_gap <= 2'd2;
      end else if (m_gap != 2'd0) m_gap <= m_gap - 2'd1;
    end
  end

  assign m_head             = m_mem[m_rd];
  assign bus.u_t_empty      = (t_mode == 1) ? 1'b1 : (t_mode == 2) ? 1'b0 : (m_busy == 2'd0);
  assign bus.u_r_ready      = r_tie | ((m_wr != m_rd) && (m_gap == 2'd0));
  assign bus.u_d_out        = m_head[7:0];
  assign bus.u_parity_error = m_head[8];
  assign bus.u_frame_error  = m_head[9];

  int wrn_pulses = 0, rdn_pulses = 0, wrn_run = 0, wrn_max_run = 0;
  logic rdn_prev = 1'b1;
  always @(negedge clk16x) begin
    if (bus.u_wrn == 1'b0) begin
      wrn_run <= wrn_run + 1;
      if (wrn_run == 0) wrn_pulses <= wrn_pulses + 1;
      if (wrn_run + 1 > wrn_max_run) wrn_max_run <= wrn_run + 1;
    end else wrn_run <= 0;
    if (bus.u_rdn == 1'b0 && rdn_prev == 1'b1) rdn_pulses <= rdn_pulses + 1;
    rdn_prev <= bus.u_rdn;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk16x);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    int k;
    k = 0;
    while (bus.tx_ready !== 1'b1 && k < 200) begin tick(1); k++; end
    chk("push_ready", 32'(bus.tx_ready), 1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic pop();
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (int'(bus.rx_level) != n && k < budget) begin tick(1); k++; end
    chk(name, 32'(bus.rx_level), 32'(n));
  endtask

  task automatic do_reset();
    bus.tx_valid = 1'b0; bus.rx_ready = 1'b0; bus.err_clr = 1'b0;
    t_mode = 0; r_tie = 1'b0; loop_en = 1'b0; inj_par = 1'b0; inj_frm = 1'b0;
    clrn = 1'b0;
    tick(2);
    clrn = 1'b1;
    tick(2);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       frm;
    logic [7:0] exp_data;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    int exp_par, exp_frm, w0, r0, k;
    vecs[0] = '{8'h55, 1'b0, 1'b0, 8'h55, 2'b00};
    vecs[1] = '{8'hA3, 1'b0, 1'b0, 8'hA3, 2'b00};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 2'b01};
    vecs[3] = '{8'h0F, 1'b0, 1'b1, 8'h0F, 2'b10};
    vecs[4] = '{8'hF0, 1'b1, 1'b1, 8'hF0, 2'b11};
    exp_par = 0; exp_frm = 0;

    bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0; bus.err_clr = 1'b0;
    clrn = 1'b0;
    tick(2);
    chk("rst_wrn",      32'(bus.u_wrn), 1);
    chk("rst_rdn",      32'(bus.u_rdn), 1);
    chk("rst_d_in",     32'(bus.u_d_in), 0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 1);
    chk("rst_rx_valid", 32'(bus.rx_valid), 0);
    chk("rst_rx_data",  32'(bus.rx_data), 0);
    chk("rst_rx_err",   32'(bus.rx_err), 0);
    chk("rst_tx_level", 32'(bus.tx_level), 0);
    chk("rst_rx_level", 32'(bus.rx_level), 0);
    chk("rst_timeout",  32'(bus.timeout), 0);
    chk("rst_par_cnt",  32'(bus.par_cnt), 0);
    chk("rst_frm_cnt",  32'(bus.frm_cnt), 0);
    clrn = 1'b1;
    tick(2);

    // loopback vectors
    loop_en = 1'b1;
    w0 = wrn_pulses;
    for (int i = 0; i < NV; i++) begin
      inj_par = vecs[i].par;
      inj_frm = vecs[i].frm;
      push(vecs[i].data);
      wait_rx(1, 60, "vec_rx_level");
      chk("vec_rx_data", 32'(bus.rx_data), 32'(vecs[i].exp_data));
      chk("vec_rx_err",  32'(bus.rx_err),  32'(vecs[i].exp_err));
`ifdef UART_ERR_CNT_EN
      exp_par += int'(vecs[i].par);
      exp_frm += int'(vecs[i].frm);
`endif
      chk("vec_par_cnt", 32'(bus.par_cnt), 32'(exp_par));
      chk("vec_frm_cnt", 32'(bus.frm_cnt), 32'(exp_frm));
      pop();
      chk("vec_pop_level", 32'(bus.rx_level), 0);
    end
    tick(2);
    chk("vec_wrn_pulses", 32'(wrn_pulses - w0), NV);
    chk("vec_wrn_width",  32'(wrn_max_run), 1);
    chk("vec_timeout",    32'(bus.timeout), 0);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    chk("clr_par_cnt", 32'(bus.par_cnt), 0);
    chk("clr_frm_cnt", 32'(bus.frm_cnt), 0);

    // TX FIFO fills while the UART transmitter stays busy
    do_reset();
    t_mode = 2;
    w0 = wrn_pulses;
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    chk("txfull_ready", 32'(bus.tx_ready), 0);
    chk("txfull_level", 32'(bus.tx_level), 8);
    bus.tx_data = 8'h99; bus.tx_valid = 1'b1;
    tick(3);
    bus.tx_valid = 1'b0;
    chk("txfull_held_level", 32'(bus.tx_level), 8);
    chk("txfull_no_strobe",  32'(wrn_pulses - w0), 0);
    loop_en = 1'b1;
    t_mode  = 0;
    wait_rx(8, 200, "txdrain_rx_level");
    for (int i = 0; i < 8; i++) begin
      chk("txdrain_order", 32'(bus.rx_data), 32'(8'h20 + i));
      pop();
    end
    chk("txdrain_empty", 32'(bus.rx_valid), 0);

    // RX FIFO full: reads stall, one pop allows exactly one more read
    do_reset();
    loop_en = 1'b1;
    for (int i = 0; i < 9; i++) push(8'(8'h40 + i));
    wait_rx(8, 300, "rxfull_level");
    tick(20);
    chk("rxfull_tx_level", 32'(bus.tx_level), 0);
    chk("rxfull_head",     32'(bus.rx_data), 32'h40);
    r0 = rdn_pulses;
    tick(40);
    chk("rxfull_stall_pulses", 32'(rdn_pulses - r0), 0);
    chk("rxfull_rdn_high",     32'(bus.u_rdn), 1);
    chk("rxfull_level_hold",   32'(bus.rx_level), 8);
    pop();
    tick(10);
    chk("rxpop_one_pulse", 32'(rdn_pulses - r0), 1);
    chk("rxpop_level",     32'(bus.rx_level), 8);
    chk("rxpop_head",      32'(bus.rx_data), 32'h41);
    chk("rxfull_timeout",  32'(bus.timeout), 0);

    // strobe timeout with t_empty stuck high
    do_reset();
    t_mode = 1;
    w0 = wrn_pulses;
    push(8'h11);
    tick(1);
    chk("to_wrn_low",  32'(bus.u_wrn), 0);
    chk("to_d_in",     32'(bus.u_d_in), 32'h11);
    tick(W);
    chk("to_not_yet",  32'(bus.timeout), 0);
    tick(1);
    chk("to_set",      32'(bus.timeout), 1);
    chk("to_tx_level", 32'(bus.tx_level), 0);
    tick(10);
    chk("to_one_strobe", 32'(wrn_pulses - w0), 1);
    chk("to_wrn_idle",   32'(bus.u_wrn), 1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    chk("to_clr", 32'(bus.timeout), 0);

    // async reset while TX waits and RX strobes
    do_reset();
    loop_en = 1'b1;
    inj_par = 1'b1;
    push(8'h66);
    wait_rx(1, 60, "mid_rx_level_pre");
`ifdef UART_ERR_CNT_EN
    chk("mid_par_pre", 32'(bus.par_cnt), 1);
`else
    chk("mid_par_pre", 32'(bus.par_cnt), 0);
`endif
    loop_en = 1'b0;
    inj_par = 1'b0;
    t_mode  = 1;
    push(8'h77);
    tick(1);
    chk("mid_wrn_low", 32'(bus.u_wrn), 0);
    push(8'h78);
    chk("mid_tx_level_pre", 32'(bus.tx_level), 1);
    r_tie = 1'b1;
    k = 0;
    while (bus.u_rdn !== 1'b0 && k < 10) begin tick(1); k++; end
    chk("mid_rdn_low", 32'(bus.u_rdn), 0);
    clrn = 1'b0;
    #1;
    chk("mid_rst_rdn",      32'(bus.u_rdn), 1);
    chk("mid_rst_wrn",      32'(bus.u_wrn), 1);
    chk("mid_rst_tx_level", 32'(bus.tx_level), 0);
    chk("mid_rst_rx_level", 32'(bus.rx_level), 0);
    chk("mid_rst_tx_ready", 32'(bus.tx_ready), 1);
    chk("mid_rst_rx_valid", 32'(bus.rx_valid), 0);
    chk("mid_rst_par_cnt",  32'(bus.par_cnt), 0);
    chk("mid_rst_d_in",     32'(bus.u_d_in), 0);
    r_tie = 1'b0;
    t_mode = 0;
    #2;
    clrn = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1);
  end

endmodule
